// File: rtl/pt_check.sv
// pt_check - printable-ASCII checker for a length-prefixed plaintext buffer.
//
// Scans PT memory after the ARC4 decrypt stage has filled it. Byte 0 holds
// the message length L and bytes 1..L hold the message. The scan reports
// whether every message byte lies in LO..HI. If one does not, it reports the
// index of the first byte that fails. The handshake is the same rdy/en
// protocol that arc4 uses.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset
//   en         start request, accepted when rdy=1
//   rdy        idle and able to accept en
//   pt_addr    PT memory read address (registered)
//   pt_rddata  PT read data, one-cycle latency after pt_addr is sampled
//   valid      last scan passed
//   bad_idx    index of the first failing byte of the last scan (0 on pass)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for en; results held
// RLEN  | memory samples address 0 (length byte)
// WLEN  | length byte available; empty message passes at once
// RCH   | memory samples the current message address
// WCH   | message byte available; range check, end test, or advance
// FIN   | one settle cycle before returning to IDLE
module pt_check #(
  parameter logic [7:0] LO = 8'h20,
  parameter logic [7:0] HI = 8'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       valid,
  output logic [7:0] bad_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RLEN,
    S_WLEN,
    S_RCH,
    S_WCH,
    S_FIN
  } state_t;

  state_t     state_q;
  logic [7:0] len_q;
  logic [7:0] addr_q;
  logic [7:0] bad_q;
  logic       valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= 8'd0;
      addr_q  <= 8'd0;
      bad_q   <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) begin
            valid_q <= 1'b0;
            bad_q   <= 8'd0;
            addr_q  <= 8'd0;
            state_q <= S_RLEN;
          end
        end
        S_RLEN: state_q <= S_WLEN;
        S_WLEN: begin
          len_q <= pt_rddata;
          if (pt_rddata == 8'd0) begin
            valid_q <= 1'b1;
            state_q <= S_FIN;
          end else begin
            addr_q  <= 8'd1;
            state_q <= S_RCH;
          end
        end
        S_RCH: state_q <= S_WCH;
        S_WCH: begin
          if ((pt_rddata < LO) || (pt_rddata > HI)) begin
            bad_q   <= addr_q;
            valid_q <= 1'b0;
            state_q <= S_FIN;
          end else if (addr_q == len_q) begin
            // End test precedes the increment, so L=255 stops at 255 without wrapping.
            valid_q <= 1'b1;
            state_q <= S_FIN;
          end else begin
            addr_q  <= addr_q + 8'd1;
            state_q <= S_RCH;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdy     = (state_q == S_IDLE);
  assign pt_addr = addr_q;
  assign valid   = valid_q;
  assign bad_idx = bad_q;

endmodule

// File: tb/tb_pt_check.sv
module tb_pt_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rdy;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic       valid;
  logic [7:0] bad_idx;

  pt_check dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .valid     (valid),
    .bad_idx   (bad_idx)
  );

  always #5 clk = ~clk;

  // PT memory model with one-cycle read latency
  logic [7:0] mem [256];
  always @(posedge clk) pt_rddata <= mem[pt_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int v;
    int bad;
    int lat;
    int max_addr;
  } exp_t;
  exp_t sb[$];

  int errs   = 0;
  int checks = 0;
  int acc_cyc;

  // Address trace of the current scan
  int  seq[$];
  int  max_addr;
  bit  seen_nz;
  bit  wrapped;

  always @(negedge clk) begin
    if (!rst && !rdy) begin
      if (seq.size() == 0 || seq[$] != int'(pt_addr)) seq.push_back(int'(pt_addr));
      if (int'(pt_addr) > max_addr) max_addr = int'(pt_addr);
      if (pt_addr != 8'd0) seen_nz = 1'b1;
      else if (seen_nz) wrapped = 1'b1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h41;
  endtask

  task automatic clear_trace();
    seq.delete();
    max_addr = 0;
    seen_nz  = 1'b0;
    wrapped  = 1'b0;
  endtask

  // Raise en at a negedge and leave it high through the accept edge.
  task automatic start_scan(input int v, input int bad, input int lat, input int mx, input bit keep_en);
    exp_t e;
    e.v = v; e.bad = bad; e.lat = lat; e.max_addr = mx;
    @(negedge clk);
    en = 1'b1;
    chk("rdy_before_accept", int'(rdy), 1);
    sb.push_back(e);
    clear_trace();
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!keep_en) en = 1'b0;
    chk("valid_cleared", int'(valid), 0);
    chk("bad_cleared", int'(bad_idx), 0);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int guard = 0;
    while (!rdy && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk({tag, "_done"}, int'(rdy), 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, int'(valid), e.v);
      chk({tag, "_bad_idx"}, int'(bad_idx), e.bad);
      chk({tag, "_latency"}, cyc - acc_cyc + 1, e.lat);
      chk({tag, "_max_addr"}, max_addr, e.max_addr);
      chk({tag, "_no_wrap"}, int'(wrapped), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clear_mem();
    clear_trace();

    // 1. reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy", int'(rdy), 1);
    chk("rst_valid", int'(valid), 0);
    chk("rst_bad", int'(bad_idx), 0);
    chk("rst_addr", int'(pt_addr), 0);
    repeat (10) @(negedge clk);
    chk("idle_rdy", int'(rdy), 1);
    chk("idle_valid", int'(valid), 0);
    chk("idle_bad", int'(bad_idx), 0);
    chk("idle_addr", int'(pt_addr), 0);

    // 2. passing message "Hello"
    clear_mem();
    mem[0] = 8'd5; mem[1] = "H"; mem[2] = "e"; mem[3] = "l"; mem[4] = "l"; mem[5] = "o";
    start_scan(1, 0, 14, 5, 1'b0);
    wait_done("hello");
    chk("hello_seq_len", seq.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < seq.size()) chk("hello_seq", seq[i], i);

    // 3. early failure at index 3
    clear_mem();
    mem[0] = 8'd6; mem[1] = "a"; mem[2] = "b"; mem[3] = 8'h1F;
    mem[4] = "c"; mem[5] = "d"; mem[6] = "e";
    start_scan(0, 3, 10, 3, 1'b0);
    wait_done("fail3");

    // 4. boundaries
    clear_mem();
    mem[0] = 8'd2; mem[1] = 8'h20; mem[2] = 8'h7E;
    start_scan(1, 0, 8, 2, 1'b0);
    wait_done("edges_ok");

    clear_mem();
    mem[0] = 8'd1; mem[1] = 8'h7F;
    start_scan(0, 1, 6, 1, 1'b0);
    wait_done("over_hi");

    clear_mem();
    mem[0] = 8'd1; mem[1] = 8'h1F;
    start_scan(0, 1, 6, 1, 1'b0);
    wait_done("under_lo");

    clear_mem();
    mem[0] = 8'd0;
    start_scan(1, 0, 4, 0, 1'b0);
    wait_done("empty");

    clear_mem();
    mem[0] = 8'd255;
    start_scan(1, 0, 514, 255, 1'b0);
    wait_done("len255");

    // 5. reset mid-scan
    clear_mem();
    mem[0] = 8'd100;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (48) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rdy", int'(rdy), 1);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_bad", int'(bad_idx), 0);
    chk("midrst_addr", int'(pt_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    start_scan(1, 0, 204, 100, 1'b0);
    wait_done("after_rst");

    // 6a. en pulsed while busy is ignored
    clear_mem();
    mem[0] = 8'd5; mem[1] = "H"; mem[2] = "e"; mem[3] = "l"; mem[4] = "l"; mem[5] = "o";
    start_scan(1, 0, 14, 5, 1'b0);
    repeat (4) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_done("busy_en");
    chk("busy_seq_len", seq.size(), 6);
    repeat (3) @(negedge clk);
    chk("busy_not_queued", int'(rdy), 1);

    // 6b. en held high across completion re-triggers
    clear_mem();
    mem[0] = 8'd3; mem[1] = "a"; mem[2] = "b"; mem[3] = "c";
    start_scan(1, 0, 10, 3, 1'b1);
    wait_done("b2b_first");
    mem[0] = 8'd4; mem[1] = "x"; mem[2] = 8'h80; mem[3] = "y"; mem[4] = "z";
    begin
      exp_t e;
      e.v = 0; e.bad = 2; e.lat = 8; e.max_addr = 2;
      sb.push_back(e);
    end
    clear_trace();
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    en = 1'b0;
    chk("b2b_retrigger_busy", int'(rdy), 0);
    chk("b2b_valid_cleared", int'(valid), 0);
    wait_done("b2b_second");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pt_check.md
Name: pt_check

Overview:
- Downstream consumer of the ARC4 decrypt stage in the key-cracking datapath.
- After arc4 leaves a length-prefixed plaintext in PT memory (byte 0 = length L, bytes 1..L = message), this block scans PT memory through its read port.
- It reports whether every message byte is printable ASCII, and otherwise the index of the first offending byte.
- The crack controller uses the result to accept the candidate key or advance to the next one.
- It uses the same rdy/en request protocol as arc4.

Parameters:
- LO, 8'h20, lowest accepted byte value (inclusive)
- HI, 8'h7E, highest accepted byte value (inclusive)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  start request; accepted only on a rising edge where rdy=1 and en=1
- rdy  output  1  high when idle and able to accept en
- pt_addr  output  8  PT memory read address (registered)
- pt_rddata  input  8  PT memory read data; holds the byte at the pt_addr value sampled on the previous rising edge (one-cycle read latency)
- valid  output  1  1 = last scan passed (all bytes within LO..HI)
- bad_idx  output  8  index of the first failing byte from the last scan; 0 when valid=1 or no scan has run

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named rst.
- Reset (rst=1 at a rising edge, from any state including mid-scan):
  - state=IDLE, rdy=1, valid=0, bad_idx=0, pt_addr=0, internal len=0.
  - Any scan in progress is abandoned and no partial result is published.
- States: IDLE, RLEN, WLEN, RCH, WCH, FIN.
- IDLE:
  - rdy=1.
  - On en=1: valid<=0, bad_idx<=0, pt_addr<=0, go to RLEN.
  - en=0 holds state and outputs.
- RLEN: rdy=0; memory samples pt_addr=0; go to WLEN.
- WLEN:
  - len<=pt_rddata.
  - If pt_rddata==0: valid<=1, go to FIN (empty message passes).
  - Otherwise: pt_addr<=1, go to RCH.
- RCH: memory samples pt_addr; go to WCH.
- WCH: let b=pt_rddata.
  - If b<LO or b>HI: bad_idx<=pt_addr, valid<=0, go to FIN (early abort; no further reads).
  - Else if pt_addr==len: valid<=1, go to FIN.
  - Else: pt_addr<=pt_addr+1, go to RCH.
- FIN: go to IDLE. rdy rises on entry to IDLE.
- Comparisons are unsigned 8-bit.
- pt_addr never wraps: the end test (pt_addr==len) is done before the increment, so L=255 reads addresses 1..255 and stops.
- Latency, counted in rising edges from the en-accept edge to the edge where rdy returns to 1:
  - all bytes pass: 2L+4 (L=0 gives 4)
  - first failure at index k: 2k+4
- valid and bad_idx:
  - change only on the en-accept edge (cleared) and in WLEN/WCH as above.
  - Otherwise they hold their values until the next accepted en.
- en while rdy=0 is ignored and not queued.
- en held high continuously re-triggers a new scan each time IDLE is re-entered.
- pt_addr is don't-care while in IDLE, but must equal 0 after reset.
- No writes to PT memory; the block is read-only.

Test Plan:
1. Reset then idle: assert rst for 2 cycles -> rdy=1, valid=0, bad_idx=0, pt_addr=0; holding en=0 for 10 cycles changes nothing.
2. Passing message: PT = {5,'H','e','l','l','o'}, pulse en -> pt_addr visits 0,1..5 in order; rdy returns high exactly 14 edges after accept; valid=1, bad_idx=0.
3. Early failure: PT = {6,'a','b',8'h1F,'c','d','e'}, pulse en -> abort after address 3 (addresses 4..6 never driven); rdy high after 10 edges; valid=0, bad_idx=3.
4. Boundaries:
   - PT = {2,8'h20,8'h7E} -> valid=1.
   - PT = {1,8'h7F} -> valid=0, bad_idx=1.
   - PT = {0} -> valid=1 after 4 edges.
   - PT = {255, 255×'A'} -> valid=1 after 514 edges, highest pt_addr=255, no wrap to 0.
5. Reset mid-scan: L=100 all-pass message, assert rst at edge 50 after accept -> next cycle rdy=1, valid=0, bad_idx=0; a fresh en then completes normally with valid=1.
6. Busy-ignore and back-to-back:
   - Pulse en again mid-scan -> no effect on address sequence or latency.
   - Hold en=1 across completion with the PT contents changed to fail at k=2 -> second scan starts on the edge rdy=1 is sampled; valid cleared, then ends valid=0, bad_idx=2.
